inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'hBFC00000, PC loaded on reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 flush_i  input  1  pipeline flush/redirect request.
REQ-005 flush_pc_i  input  32  redirect target, sampled when flush_i=1.
REQ-006 buffer_full_i  input  1  instruction buffer near-full; no new fetch may start while 1.
REQ-007 cpu_req_o  output  1  ICache request valid.
REQ-008 cpu_addr_o  output  32  ICache request address (current PC).
REQ-009 icache_addr_ok_i  input  1  ICache accepted the request this cycle.
REQ-010 icache_data_ok_i  input  1  ICache returns data this cycle (at least 1 cycle after addr_ok).
REQ-011 icache_rdata1_i / icache_rdata2_i  input  32 each  words at {addr[31:3],3'b000} and +4.
REQ-012 fetch_inst1_o / fetch_inst2_o  output  32 each  instructions pushed to buffer.
REQ-013 fetch_addr1_o / fetch_addr2_o  output  32 each  their PCs.
REQ-014 fetch_valid1_o / fetch_valid2_o  output  1 each  one-cycle push strobes to buffer.

Function
REQ-015 FSM states SHALL be IDLE, REQ, WAIT, DISCARD, HOLD; at most one request outstanding.
REQ-016 cpu_req_o SHALL equal (state==REQ); cpu_addr_o SHALL equal pc register, stable while in REQ.
REQ-017 IDLE -> REQ when buffer_full_i=0 and flush_i=0; else stay IDLE.
REQ-018 REQ -> WAIT on icache_addr_ok_i=1; otherwise stay REQ.
REQ-019 WAIT on icache_data_ok_i=1: if buffer_full_i=0, push data (outputs valid next cycle) and -> IDLE; if buffer_full_i=1, capture data into hold register and -> HOLD.
REQ-020 HOLD -> IDLE, pushing held data, in the first cycle buffer_full_i=0.
REQ-021 Push lanes: pc[2]=0 -> inst1=rdata1, addr1=pc, inst2=rdata2, addr2=pc+4, both valid, next pc=pc+8.
REQ-022 pc[2]=1 -> inst1=rdata2, addr1=pc, valid1=1, valid2=0, inst2/addr2=0, next pc=pc+4.
REQ-023 pc SHALL advance only in the cycle data is pushed to the buffer; PC arithmetic wraps modulo 2^32.
REQ-024 fetch_valid*_o SHALL be registered single-cycle pulses; latency data_ok -> valid = 1 cycle when not full.
REQ-025 Flush priority over all other events; flush_i=1 SHALL load pc=flush_pc_i and suppress any push that cycle.
REQ-026 Flush in IDLE or HOLD -> IDLE (held data dropped).
REQ-027 Flush in REQ without addr_ok -> IDLE (request withdrawn); with addr_ok same cycle -> DISCARD.
REQ-028 Flush in WAIT without data_ok -> DISCARD; with data_ok same cycle -> IDLE, data dropped.
REQ-029 DISCARD: on data_ok -> IDLE with no push; further flush in DISCARD updates pc, stays DISCARD unless data_ok.
REQ-030 No push strobe SHALL ever carry data from a request issued before the most recent flush.

Reset
REQ-031 rst=1 SHALL set state=IDLE, pc=RESET_PC, hold register cleared, cpu_req_o=0, all fetch_*_o=0, overriding flush_i.
REQ-032 Reset mid-request SHALL abandon the request; the ICache is reset together with this block, so no stale data_ok is expected.

Verification
REQ-033 Reset release, buffer_full_i=0, addr_ok next cycle, data_ok 2 cycles later with 11111111/22222222 -> cpu_addr_o=BFC00000, push inst1=11111111@BFC00000, inst2=22222222@BFC00004, next cpu_addr_o=BFC00008.
REQ-034 flush_pc_i=80000004 in IDLE, data 0/AAAA0000 -> single push inst1=AAAA0000@80000004, valid2=0, next addr 80000008.
REQ-035 Flush to 80001000 while in WAIT, then data_ok -> no push strobe; next request address 80001000.
REQ-036 buffer_full_i=1 at data_ok, held 3 cycles -> no push while full, push of held data 1 cycle after buffer_full_i falls, no new req until then.
REQ-037 Flush coincident with addr_ok in REQ -> DISCARD entered, returned data dropped, next req at flush target.
REQ-038 pc=FFFFFFF8, normal fetch -> addresses FFFFFFF8/FFFFFFFC pushed, next pc=00000000.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch stage: walks the PC, issues one ICache request at a
// time and pushes one or two instructions per response into the
// instruction buffer. Redirects (flush) discard any in-flight response.
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush_i,
   input  logic [31:0] flush_pc_i,
   input  logic        buffer_full_i,
   output logic        cpu_req_o,
   output logic [31:0] cpu_addr_o,
   input  logic        icache_addr_ok_i,
   input  logic        icache_data_ok_i,
   input  logic [31:0] icache_rdata1_i,
   input  logic [31:0] icache_rdata2_i,
   output logic [31:0] fetch_inst1_o,
   output logic [31:0] fetch_inst2_o,
   output logic [31:0] fetch_addr1_o,
   output logic [31:0] fetch_addr2_o,
   output logic        fetch_valid1_o,
   output logic        fetch_valid2_o
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_REQ     = 3'd1;
   localparam logic [2:0] S_WAIT    = 3'd2;
   localparam logic [2:0] S_DISCARD = 3'd3;
   localparam logic [2:0] S_HOLD    = 3'd4;

   logic [2:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] hold1_q, hold1_d;
   logic [31:0] hold2_q, hold2_d;
   logic [31:0] inst1_q, inst1_d;
   logic [31:0] inst2_q, inst2_d;
   logic [31:0] addr1_q, addr1_d;
   logic [31:0] addr2_q, addr2_d;
   logic        valid1_q, valid1_d;
   logic        valid2_q, valid2_d;

   logic        push;
   logic [31:0] src1, src2;

   assign cpu_req_o      = (state_q == S_REQ);
   assign cpu_addr_o     = pc_q;
   assign fetch_inst1_o  = inst1_q;
   assign fetch_inst2_o  = inst2_q;
   assign fetch_addr1_o  = addr1_q;
   assign fetch_addr2_o  = addr2_q;
   assign fetch_valid1_o = valid1_q;
   assign fetch_valid2_o = valid2_q;

   // Next-state, PC, hold capture and push lane selection; flush wins over everything
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      hold1_d  = hold1_q;
      hold2_d  = hold2_q;
      push     = 1'b0;
      src1     = icache_rdata1_i;
      src2     = icache_rdata2_i;
      inst1_d  = inst1_q;
      inst2_d  = inst2_q;
      addr1_d  = addr1_q;
      addr2_d  = addr2_q;
      valid1_d = 1'b0;
      valid2_d = 1'b0;

      if (flush_i) begin
         pc_d = flush_pc_i;
         case (state_q)
            S_REQ:     state_d = icache_addr_ok_i ? S_DISCARD : S_IDLE;
            S_WAIT:    state_d = icache_data_ok_i ? S_IDLE : S_DISCARD;
            S_DISCARD: state_d = icache_data_ok_i ? S_IDLE : S_DISCARD;
            default:   state_d = S_IDLE;
         endcase
      end else begin
         case (state_q)
            S_IDLE: begin
               if (!buffer_full_i) state_d = S_REQ;
            end
            S_REQ: begin
               if (icache_addr_ok_i) state_d = S_WAIT;
            end
            S_WAIT: begin
               if (icache_data_ok_i) begin
                  if (buffer_full_i) begin
                     hold1_d = icache_rdata1_i;
                     hold2_d = icache_rdata2_i;
                     state_d = S_HOLD;
                  end else begin
                     push    = 1'b1;
                     state_d = S_IDLE;
                  end
               end
            end
            S_DISCARD: begin
               if (icache_data_ok_i) state_d = S_IDLE;
            end
            S_HOLD: begin
               src1 = hold1_q;
               src2 = hold2_q;
               if (!buffer_full_i) begin
                  push    = 1'b1;
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      if (push) begin
         valid1_d = 1'b1;
         addr1_d  = pc_q;
         if (!pc_q[2]) begin
            inst1_d  = src1;
            inst2_d  = src2;
            addr2_d  = pc_q + 32'd4;
            valid2_d = 1'b1;
            pc_d     = pc_q + 32'd8;
         end else begin
            inst1_d  = src2;
            inst2_d  = '0;
            addr2_d  = '0;
            pc_d     = pc_q + 32'd4;
         end
      end
   end

   // State, PC, hold buffer and registered push outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         pc_q     <= RESET_PC;
         hold1_q  <= '0;
         hold2_q  <= '0;
         inst1_q  <= '0;
         inst2_q  <= '0;
         addr1_q  <= '0;
         addr2_q  <= '0;
         valid1_q <= 1'b0;
         valid2_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         hold1_q  <= hold1_d;
         hold2_q  <= hold2_d;
         inst1_q  <= inst1_d;
         inst2_q  <= inst2_d;
         addr1_q  <= addr1_d;
         addr2_q  <= addr2_d;
         valid1_q <= valid1_d;
         valid2_q <= valid2_d;
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: drives the ICache handshake by hand,
// checks against hand-computed addresses and push strobes.
module tb_inst_fetch;

   logic        clk;
   logic        rst;
   logic        flush_i;
   logic [31:0] flush_pc_i;
   logic        buffer_full_i;
   logic        cpu_req_o;
   logic [31:0] cpu_addr_o;
   logic        icache_addr_ok_i;
   logic        icache_data_ok_i;
   logic [31:0] icache_rdata1_i;
   logic [31:0] icache_rdata2_i;
   logic [31:0] fetch_inst1_o;
   logic [31:0] fetch_inst2_o;
   logic [31:0] fetch_addr1_o;
   logic [31:0] fetch_addr2_o;
   logic        fetch_valid1_o;
   logic        fetch_valid2_o;

   int unsigned n_checks;
   int unsigned n_fail;

   inst_fetch #(.RESET_PC(32'hBFC00000)) dut (
      .clk              (clk),
      .rst              (rst),
      .flush_i          (flush_i),
      .flush_pc_i       (flush_pc_i),
      .buffer_full_i    (buffer_full_i),
      .cpu_req_o        (cpu_req_o),
      .cpu_addr_o       (cpu_addr_o),
      .icache_addr_ok_i (icache_addr_ok_i),
      .icache_data_ok_i (icache_data_ok_i),
      .icache_rdata1_i  (icache_rdata1_i),
      .icache_rdata2_i  (icache_rdata2_i),
      .fetch_inst1_o    (fetch_inst1_o),
      .fetch_inst2_o    (fetch_inst2_o),
      .fetch_addr1_o    (fetch_addr1_o),
      .fetch_addr2_o    (fetch_addr2_o),
      .fetch_valid1_o   (fetch_valid1_o),
      .fetch_valid2_o   (fetch_valid2_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expected value
   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_nopush(input string tag);
      check_eq({tag, "_v1"}, {31'd0, fetch_valid1_o}, 32'd0);
      check_eq({tag, "_v2"}, {31'd0, fetch_valid2_o}, 32'd0);
   endtask

   task automatic check_req(input string tag, input logic [31:0] addr);
      check_eq({tag, "_req"}, {31'd0, cpu_req_o}, 32'd1);
      check_eq({tag, "_addr"}, cpu_addr_o, addr);
   endtask

   task automatic check_push(input string tag, input logic v2,
                             input logic [31:0] i1, input logic [31:0] a1,
                             input logic [31:0] i2, input logic [31:0] a2);
      check_eq({tag, "_v1"}, {31'd0, fetch_valid1_o}, 32'd1);
      check_eq({tag, "_v2"}, {31'd0, fetch_valid2_o}, {31'd0, v2});
      check_eq({tag, "_i1"}, fetch_inst1_o, i1);
      check_eq({tag, "_a1"}, fetch_addr1_o, a1);
      check_eq({tag, "_i2"}, fetch_inst2_o, i2);
      check_eq({tag, "_a2"}, fetch_addr2_o, a2);
   endtask

   initial begin
      n_checks         = 0;
      n_fail           = 0;
      rst              = 1'b1;
      flush_i          = 1'b1;
      flush_pc_i       = 32'h12345678;
      buffer_full_i    = 1'b0;
      icache_addr_ok_i = 1'b0;
      icache_data_ok_i = 1'b0;
      icache_rdata1_i  = '0;
      icache_rdata2_i  = '0;

      // Reset overrides a concurrent flush
      tick();
      tick();
      flush_i = 1'b0;
      check_eq("rst_req", {31'd0, cpu_req_o}, 32'd0);
      check_eq("rst_addr", cpu_addr_o, 32'hBFC00000);
      check_nopush("rst");
      check_eq("rst_i1", fetch_inst1_o, 32'd0);
      check_eq("rst_a2", fetch_addr2_o, 32'd0);

      // Basic aligned fetch from reset vector
      rst = 1'b0;
      tick();
      check_req("f0", 32'hBFC00000);
      icache_addr_ok_i = 1'b1;
      tick();
      icache_addr_ok_i = 1'b0;
      check_eq("f0_wait_req", {31'd0, cpu_req_o}, 32'd0);
      tick();
      icache_data_ok_i = 1'b1;
      icache_rdata1_i  = 32'h11111111;
      icache_rdata2_i  = 32'h22222222;
      tick();
      icache_data_ok_i = 1'b0;
      check_push("f0", 1'b1, 32'h11111111, 32'hBFC00000, 32'h22222222, 32'hBFC00004);

      // Flush in IDLE to an odd-word target -> single-lane push
      flush_i    = 1'b1;
      flush_pc_i = 32'h80000004;
      tick();
      flush_i = 1'b0;
      check_eq("f1_idle_req", {31'd0, cpu_req_o}, 32'd0);
      check_nopush("f0_pulse");
      tick();
      check_req("f1", 32'h80000004);
      icache_addr_ok_i = 1'b1;
      tick();
      icache_addr_ok_i = 1'b0;
      icache_data_ok_i = 1'b1;
      icache_rdata1_i  = 32'h00000000;
      icache_rdata2_i  = 32'hAAAA0000;
      tick();
      icache_data_ok_i = 1'b0;
      check_push("f1", 1'b0, 32'hAAAA0000, 32'h80000004, 32'd0, 32'd0);
      tick();
      check_req("f2", 32'h80000008);
      check_nopush("f1_pulse");

      // Flush while waiting for data -> response dropped
      icache_addr_ok_i = 1'b1;
      tick();
      icache_addr_ok_i = 1'b0;
      flush_i    = 1'b1;
      flush_pc_i = 32'h80001000;
      tick();
      flush_i = 1'b0;
      check_eq("disc_req", {31'd0, cpu_req_o}, 32'd0);
      tick();
      icache_data_ok_i = 1'b1;
      icache_rdata1_i  = 32'hDEADBEEF;
      icache_rdata2_i  = 32'hDEADBEEF;
      tick();
      icache_data_ok_i = 1'b0;
      check_nopush("disc");
      tick();
      check_req("f3", 32'h80001000);

      // Buffer full at data_ok -> held, pushed one cycle after full falls
      icache_addr_ok_i = 1'b1;
      tick();
      icache_addr_ok_i = 1'b0;
      icache_data_ok_i = 1'b1;
      buffer_full_i    = 1'b1;
      icache_rdata1_i  = 32'h33333333;
      icache_rdata2_i  = 32'h44444444;
      tick();
      icache_data_ok_i = 1'b0;
      icache_rdata1_i  = 32'h99999999;
      icache_rdata2_i  = 32'h88888888;
      for (int unsigned k = 0; k < 3; k++) begin
         check_nopush("hold");
         check_eq("hold_req", {31'd0, cpu_req_o}, 32'd0);
         tick();
      end
      buffer_full_i = 1'b0;
      check_nopush("hold_last");
      tick();
      check_push("hold", 1'b1, 32'h33333333, 32'h80001000, 32'h44444444, 32'h80001004);
      check_eq("hold_noreq", {31'd0, cpu_req_o}, 32'd0);
      tick();
      check_req("f4", 32'h80001008);

      // Flush coincident with addr_ok -> DISCARD
      icache_addr_ok_i = 1'b1;
      flush_i          = 1'b1;
      flush_pc_i       = 32'h80002000;
      tick();
      icache_addr_ok_i = 1'b0;
      flush_i          = 1'b0;
      check_eq("disc2_req", {31'd0, cpu_req_o}, 32'd0);
      tick();
      check_eq("disc2_stay", {31'd0, cpu_req_o}, 32'd0);
      icache_data_ok_i = 1'b1;
      icache_rdata1_i  = 32'hBAD00000;
      icache_rdata2_i  = 32'hBAD00004;
      tick();
      icache_data_ok_i = 1'b0;
      check_nopush("disc2");
      tick();
      check_req("f5", 32'h80002000);

      // Flush in REQ without addr_ok -> request withdrawn
      flush_i    = 1'b1;
      flush_pc_i = 32'h80003000;
      tick();
      flush_i = 1'b0;
      check_eq("wd_req", {31'd0, cpu_req_o}, 32'd0);
      tick();
      check_req("f6", 32'h80003000);

      // Flush coincident with data_ok in WAIT -> data dropped
      icache_addr_ok_i = 1'b1;
      tick();
      icache_addr_ok_i = 1'b0;
      flush_i          = 1'b1;
      flush_pc_i       = 32'hFFFFFFF8;
      icache_data_ok_i = 1'b1;
      tick();
      flush_i          = 1'b0;
      icache_data_ok_i = 1'b0;
      check_nopush("wflush");
      tick();
      check_req("f7", 32'hFFFFFFF8);

      // PC wrap at top of address space
      icache_addr_ok_i = 1'b1;
      tick();
      icache_addr_ok_i = 1'b0;
      icache_data_ok_i = 1'b1;
      icache_rdata1_i  = 32'h55555555;
      icache_rdata2_i  = 32'h66666666;
      tick();
      icache_data_ok_i = 1'b0;
      check_push("wrap", 1'b1, 32'h55555555, 32'hFFFFFFF8, 32'h66666666, 32'hFFFFFFFC);
      tick();
      check_req("f8", 32'h00000000);

      // Flush in HOLD drops held data
      icache_addr_ok_i = 1'b1;
      tick();
      icache_addr_ok_i = 1'b0;
      icache_data_ok_i = 1'b1;
      buffer_full_i    = 1'b1;
      tick();
      icache_data_ok_i = 1'b0;
      flush_i          = 1'b1;
      flush_pc_i       = 32'h80004000;
      tick();
      flush_i       = 1'b0;
      buffer_full_i = 1'b0;
      check_nopush("hflush");
      tick();
      check_nopush("hflush2");
      check_req("f9", 32'h80004000);

      // Reset mid-request
      icache_addr_ok_i = 1'b1;
      tick();
      icache_addr_ok_i = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("rst2_req", {31'd0, cpu_req_o}, 32'd0);
      check_eq("rst2_addr", cpu_addr_o, 32'hBFC00000);
      tick();
      check_req("f10", 32'hBFC00000);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
